fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS pipeline.
- Owns the PC and drives the icache request.
- Consumes hazard, branch and jump from the hazard unit to stall, redirect or flush.
- Presents the fetched instruction and next-PC to decode.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding treated as HALT.

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  synchronous active-high reset
- ihit  in  1  icache returns valid instruction for imemaddr this cycle
- imemload  in  32  instruction word from icache
- imemREN  out  1  icache read enable
- imemaddr  out  32  fetch address (current PC)
- hazard  in  1  stall request: hold PC and IF/ID
- branch  in  1  taken branch resolved in decode
- branch_target  in  32  branch destination
- jump  in  1  J/JAL in decode
- jump_target  in  32  jump destination
- ifid_instr  out  32  latched instruction to decode
- ifid_npc  out  32  latched PC+4 of that instruction
- ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble)
- halted  out  1  fetch has stopped on HALT

Behaviour:
- Reset (RST high at an edge)
  - PC <= PC_INIT; state <= BOOT.
  - ifid_instr <= 0, ifid_npc <= 0, ifid_valid <= 0, halted <= 0.
  - RST overrides every other input.
- States:
  - BOOT: imemREN=0 for exactly one cycle, then RUN unconditionally.
  - RUN: imemREN=1.
  - HALTED: imemREN=0, all registers frozen, halted=1; exit only by RST.
- imemaddr = {PC[31:2], 2'b00} at all times. The PC register never holds nonzero low bits; target bits [1:0] are discarded.
- RUN per-cycle priority (highest first):
  1. Redirect: branch=1 -> PC <= branch_target; else jump=1 -> PC <= jump_target.
     - IF/ID flushed: ifid_instr <= 0, ifid_valid <= 0, ifid_npc <= 0.
     - ihit is ignored and hazard is ignored.
     - The instruction being fetched is discarded, even if it is HALT_WORD.
     - branch and jump together: branch wins.
  2. hazard=1 -> PC and IF/ID hold their values; ihit is ignored. The same address is re-requested next cycle.
  3. ihit=1:
     - ifid_instr <= imemload, ifid_npc <= PC+4, ifid_valid <= 1.
     - PC <= PC+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  4. ihit=0 (miss) -> PC holds.
     - IF/ID <= bubble: ifid_instr 0, ifid_valid 0, ifid_npc 0.
     - imemREN stays 1 until ihit.
- HALT:
  - Condition: ihit=1, imemload == HALT_WORD, and no redirect or hazard that cycle.
  - HALT_WORD is latched into IF/ID with valid=1, and PC advances to PC+4.
  - State -> HALTED; imemREN drops the following cycle.
- Latency:
  - An instruction returned with ihit at cycle N is visible on ifid_* at cycle N+1.
  - Redirect at cycle N: the first fetch of the target is issued at N+1.
- No combinational path from ihit or imemload to ifid_*. imemREN is a function of state only.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, add three outputs:
  - perf_fetched (32): count of ihit-accepted instructions, HALT included.
  - perf_stall (32): count of RUN cycles with hazard=1 and no redirect.
  - perf_miss (32): count of RUN cycles with ihit=0, no redirect, no hazard.
- Counters reset to 0 on RST and saturate at 32'hFFFF_FFFF.
- They freeze in HALTED.
- Without the macro, none of these ports or registers exist and behaviour is otherwise identical.

Test Plan:
- Straight-line fetch: reset with PC_INIT=0, ihit=1 always, words A,B,C.
  - imemREN=0 in the first cycle, then fetches 0,4,8.
  - ifid_instr=A/npc=4, then B/8, then C/12, valid=1.
- Stall: hazard=1 for 2 cycles while ifid holds B.
  - ifid stays B/8 and imemaddr stays 8 for both cycles.
  - Then C is latched with npc 12.
- Redirect over hazard: branch=1, hazard=1, ihit=1, branch_target=32'h0000_0103.
  - Next cycle imemaddr=0x100, ifid_valid=0, ifid_instr=0.
- Branch and jump simultaneous: branch_target=0x40, jump_target=0x80 -> imemaddr=0x40.
- Miss then halt:
  - ihit=0 for 3 cycles -> bubbles, PC held.
  - Then ihit with 0xFFFFFFFF -> ifid_instr=FFFFFFFF, valid=1, halted=1.
  - imemREN=0 and the PC stays frozen until RST.
  - If FETCH_PERF_EN: perf_miss=3, perf_fetched increments by 1.
- Reset mid-operation: RST during a miss and a pending branch.
  - Next cycle PC=PC_INIT, ifid zeroed, state BOOT; the branch is ignored.
- PC wrap: PC=0xFFFFFFFC with ihit -> ifid_npc=0 and next imemaddr=0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage and IF/ID pipeline register for the
// 5-stage MIPS pipeline. Owns the PC, drives the icache request, and applies
// stall / redirect / flush requests from the hazard unit.
//
// Optional feature: define FETCH_PERF_EN to add the perf_fetched, perf_stall
// and perf_miss saturating event counters.
module fetch_unit #(
    parameter logic [31:0] PC_INIT   = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        hazard,
    input  logic        branch,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_npc,
    output logic        ifid_valid,
    output logic        halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_miss
`endif
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] instr_next, npc_next;
    logic        valid_next;
    logic        fetch_evt, stall_evt, miss_evt;

    assign pc_plus4 = pc + 32'd4;
    // The PC is always word aligned, but mask anyway so the address bus is
    // guaranteed clean even if a stray low bit ever got in.
    assign imemaddr = pc & WORD_MASK;
    assign halted   = (state == HALTED);

    // Next-state, next-PC, IF/ID next values and the icache enable.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can
        // leave one unassigned and infer a latch.
        state_next = state;
        pc_next    = pc;
        instr_next = ifid_instr;
        npc_next   = ifid_npc;
        valid_next = ifid_valid;
        imemREN    = 1'b0;
        fetch_evt  = 1'b0;
        stall_evt  = 1'b0;
        miss_evt   = 1'b0;

        case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                imemREN = 1'b1;
                if (branch || jump) begin
                    // Redirect beats everything; the word in flight is dropped.
                    pc_next    = (branch ? branch_target : jump_target) & WORD_MASK;
                    instr_next = 32'd0;
                    npc_next   = 32'd0;
                    valid_next = 1'b0;
                end else if (hazard) begin
                    stall_evt = 1'b1;
                end else if (ihit) begin
                    pc_next    = pc_plus4;
                    instr_next = imemload;
                    npc_next   = pc_plus4;
                    valid_next = 1'b1;
                    fetch_evt  = 1'b1;
                    if (imemload == HALT_WORD) begin
                        state_next = HALTED;
                    end
                end else begin
                    // Miss: hold the PC and push a bubble into decode.
                    instr_next = 32'd0;
                    npc_next   = 32'd0;
                    valid_next = 1'b0;
                    miss_evt   = 1'b1;
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // State, PC and IF/ID registers with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (RST) begin
            state      <= BOOT;
            pc         <= PC_INIT & WORD_MASK;
            ifid_instr <= 32'd0;
            ifid_npc   <= 32'd0;
            ifid_valid <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            ifid_instr <= instr_next;
            ifid_npc   <= npc_next;
            ifid_valid <= valid_next;
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating event counters; events only fire in RUN so they freeze in HALTED.
    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_fetched <= 32'd0;
            perf_stall   <= 32'd0;
            perf_miss    <= 32'd0;
        end else begin
            if (fetch_evt && perf_fetched != 32'hFFFF_FFFF) perf_fetched <= perf_fetched + 32'd1;
            if (stall_evt && perf_stall   != 32'hFFFF_FFFF) perf_stall   <= perf_stall + 32'd1;
            if (miss_evt  && perf_miss    != 32'hFFFF_FFFF) perf_miss    <= perf_miss + 32'd1;
        end
    end
`else
    // Event strobes have no consumer without the counters.
    logic unused_evt;
    assign unused_evt = fetch_evt ^ stall_evt ^ miss_evt;
`endif

endmodule
